clipper_timebase: RTL and testbench
===================================

Name: clipper_timebase

Overview:
- Time-of-day (ToD) generator for the clipper datapath.
- Consumes the timebase control signals driven by the bench control interface: force, accelerate, load value and flowmeter freeze.
- Produces the running 64-bit ToD, a freezable flowmeter timestamp and a 1PPS pulse for downstream timestamping and flowmeter logic.

Parameters:
- NS_PER_CLK, 8, nanoseconds added per clk in normal mode (125 MHz clock).
- ACCEL_SHIFT, 10, accelerate mode adds NS_PER_CLK << ACCEL_SHIFT per clk. Elaboration check: result < 1_000_000_000.
- PPS_WIDTH, 4, 1PPS pulse width in clk cycles; must be ≥ 1.
- FRAC_NS, 16'h0000, fractional ns per clk (Q0.16). Used only with the optional feature.

Ports:
- clk  in  1  timebase clock
- rst  in  1  asynchronous, active-high reset
- timebase_force  in  1  load timebase_time into ToD
- timebase_accelerate  in  1  select accelerated increment
- timebase_time  in  64  load value, {sec[31:0], ns[31:0]}
- freeze_flowmeter_time  in  1  hold flowmeter_time
- tod  out  64  current ToD, {sec, ns}
- tod_valid  out  1  ToD has been loaded at least once since reset
- flowmeter_time  out  64  ToD copy for flowmeter, freezable
- pps  out  1  1PPS pulse, asserted on seconds rollover

Behaviour:
- Reset values: tod = 0, tod_valid = 0, flowmeter_time = 0, pps = 0, internal pulse counter = 0, fraction accumulator = 0.
- All outputs are registered. ToD counts from reset even while tod_valid = 0.
- Increment per cycle:
  - inc = NS_PER_CLK, or NS_PER_CLK << ACCEL_SHIFT when timebase_accelerate = 1.
  - accelerate is sampled every cycle, with no hysteresis.
- Rollover:
  - sum = ns + inc, computed 32-bit plus one carry bit.
  - If sum ≥ 1_000_000_000: ns ← sum − 1_000_000_000, sec ← sec + 1.
  - sec wraps 32'hFFFF_FFFF → 0. Wrap still counts as a rollover.
- Force:
  - When timebase_force = 1 at a clk edge: tod ← timebase_time. This takes priority over the increment and over accelerate.
  - Loaded value is visible 1 cycle after force is sampled.
  - If force is held high, tod tracks timebase_time every cycle.
  - If the loaded ns field ≥ 1_000_000_000, ns saturates to 999_999_999; sec loads unchanged.
  - Force never generates pps.
- tod_valid FSM, two states:
  - UNSYNC → SYNC on the first force.
  - SYNC holds until rst. There is no other exit.
  - tod_valid = (state == SYNC), asserted the same cycle the loaded value appears.
- flowmeter_time:
  - freeze = 0: flowmeter_time ← next tod value, i.e. equal to tod in the same cycle.
  - freeze = 1: holds its last value.
  - On deassertion of freeze, flowmeter_time equals tod from the next cycle.
  - Force while frozen does not update it.
- pps:
  - Asserted the cycle tod shows the incremented sec.
  - Held for PPS_WIDTH cycles via a down-counter.
  - A rollover during an active pulse reloads the counter; no gap, no double edge.
- Reset mid-operation: asynchronous clear of all state. First increment occurs on the first clk edge after rst deasserts.

Optional Feature:
- Macro: CLIPPER_TIMEBASE_DRIFT_EN.
- Defined:
  - A 16-bit fractional accumulator adds FRAC_NS each cycle.
  - A carry out adds 1 ns to inc that cycle, before the rollover compare.
  - Force clears the accumulator.
- Undefined:
  - No accumulator; FRAC_NS is ignored.
  - Increment is integer only.

Decomposition:
- clipper_pkg additions:
  - CLIPPER_NS_PER_SEC = 1_000_000_000.
  - clipper_tod_t: packed struct {logic [31:0] sec; logic [31:0] ns;}.
  - clipper_tod_state_e: {TOD_UNSYNC, TOD_SYNC}.
- Sub-module: clipper_timebase_pps, a pulse stretcher with a rollover strobe in and pps out, parameter PPS_WIDTH.

Test Plan:
- Reset, then 10 clk with no force → tod = {0, 80}, tod_valid = 0, pps = 0.
- Force {5, 999_999_992}, then 1 increment → tod = {6, 0}, pps high for exactly 4 cycles, tod_valid = 1.
- Accelerate with ns = 999_995_000 → next ns = 3_192, sec + 1; drop accelerate → increment returns to 8.
- Force {32'hFFFF_FFFF, 999_999_992}, then 1 increment → tod = {0, 0}, pps asserted.
- Freeze at tod = {2, 400}, hold 20 cycles → flowmeter_time stays {2, 400} while tod advances; release → equal to tod next cycle.
- Force with ns = 32'hFFFF_FFFF → ns = 999_999_999. With CLIPPER_TIMEBASE_DRIFT_EN and FRAC_NS = 16'h8000 → ns advances 8, 9, 8, 9 alternately.

Source files
------------

// File: rtl/clipper_pkg.sv
// Shared types and constants for the clipper time-of-day logic.
package clipper_pkg;

  localparam logic [31:0] CLIPPER_NS_PER_SEC = 32'd1_000_000_000;

  typedef struct packed {
    logic [31:0] sec;
    logic [31:0] ns;
  } clipper_tod_t;

  typedef enum logic [0:0] {
    TOD_UNSYNC = 1'b0,
    TOD_SYNC   = 1'b1
  } clipper_tod_state_e;

  // A loaded ns field outside one second is clamped to the last valid ns.
  function automatic logic [31:0] clipper_sat_ns(input logic [31:0] ns);
    return (ns >= CLIPPER_NS_PER_SEC) ? (CLIPPER_NS_PER_SEC - 32'd1) : ns;
  endfunction

endpackage

// File: rtl/clipper_timebase_pps.sv
// 1PPS pulse stretcher: a rollover strobe (re)starts a PPS_WIDTH-cycle pulse.
module clipper_timebase_pps
  import clipper_pkg::*;
#(
  parameter int unsigned PPS_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rollover,
  output logic pps
);

  localparam int unsigned CW = $clog2(PPS_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PPS_WIDTH);

  if (PPS_WIDTH < 1) begin : g_bad_width
    $error("clipper_timebase_pps: PPS_WIDTH must be at least 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pps_q, pps_d;

  // A rollover mid-pulse reloads the counter so the pulse simply extends.
  always_comb begin
    cnt_d = cnt_q;
    if (rollover) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    pps_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      pps_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pps_q <= pps_d;
    end
  end

  assign pps = pps_q;

endmodule

// File: rtl/clipper_timebase.sv
// Time-of-day generator: running {sec, ns}, freezable flowmeter copy and 1PPS.
// Optional fractional-ns drift accumulator under `CLIPPER_TIMEBASE_DRIFT_EN.
//
// state      | meaning
// TOD_UNSYNC | ToD free-running from reset, never loaded
// TOD_SYNC   | ToD loaded at least once; held until reset
module clipper_timebase
  import clipper_pkg::*;
#(
  parameter int unsigned NS_PER_CLK  = 8,
  parameter int unsigned ACCEL_SHIFT = 10,
  parameter int unsigned PPS_WIDTH   = 4,
  parameter logic [15:0] FRAC_NS     = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timebase_force,
  input  logic        timebase_accelerate,
  input  logic [63:0] timebase_time,
  input  logic        freeze_flowmeter_time,
  output logic [63:0] tod,
  output logic        tod_valid,
  output logic [63:0] flowmeter_time,
  output logic        pps
);

  localparam logic [0:0] ST_UNSYNC = TOD_UNSYNC;
  localparam logic [0:0] ST_SYNC   = TOD_SYNC;

  localparam longint unsigned ACCEL_INC = longint'(NS_PER_CLK) << ACCEL_SHIFT;
  localparam logic [31:0] INC_NORM  = NS_PER_CLK[31:0];
  localparam logic [31:0] INC_ACCEL = ACCEL_INC[31:0];

  if (ACCEL_INC >= 64'd1_000_000_000) begin : g_bad_accel
    $error("clipper_timebase: accelerated increment must stay below one second");
  end

  clipper_tod_t tod_q, tod_d;
  clipper_tod_t fm_q, fm_d;
  logic [0:0]   state_q, state_d;
  logic [31:0]  inc;
  logic [32:0]  sum;
  logic [32:0]  sum_wrap;
  logic         rollover;

`ifdef CLIPPER_TIMEBASE_DRIFT_EN
  logic [15:0] frac_q, frac_d;
  logic [16:0] frac_sum;
`else
  // FRAC_NS only matters when the drift accumulator is built in.
  if (FRAC_NS != 16'h0000) begin : g_frac_ignored
  end
`endif

  always_comb begin
    inc = timebase_accelerate ? INC_ACCEL : INC_NORM;
`ifdef CLIPPER_TIMEBASE_DRIFT_EN
    frac_sum = {1'b0, frac_q} + {1'b0, FRAC_NS};
    inc      = inc + {31'd0, frac_sum[16]};
    frac_d   = timebase_force ? 16'h0000 : frac_sum[15:0];
`endif
    sum      = {1'b0, tod_q.ns} + {1'b0, inc};
    sum_wrap = sum - {1'b0, CLIPPER_NS_PER_SEC};
    rollover = 1'b0;
    tod_d    = tod_q;

    // Force wins over increment and accelerate and never counts as a rollover.
    if (timebase_force) begin
      tod_d.sec = timebase_time[63:32];
      tod_d.ns  = clipper_sat_ns(timebase_time[31:0]);
    end else if (sum >= {1'b0, CLIPPER_NS_PER_SEC}) begin
      rollover  = 1'b1;
      tod_d.ns  = sum_wrap[31:0];
      tod_d.sec = tod_q.sec + 32'd1;
    end else begin
      tod_d.ns  = sum[31:0];
    end

    state_d = timebase_force ? ST_SYNC : state_q;
    fm_d    = freeze_flowmeter_time ? fm_q : tod_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tod_q   <= '0;
      fm_q    <= '0;
      state_q <= ST_UNSYNC;
    end else begin
      tod_q   <= tod_d;
      fm_q    <= fm_d;
      state_q <= state_d;
    end
  end

`ifdef CLIPPER_TIMEBASE_DRIFT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frac_q <= '0;
    end else begin
      frac_q <= frac_d;
    end
  end
`endif

  clipper_timebase_pps #(
    .PPS_WIDTH (PPS_WIDTH)
  ) u_pps (
    .clk      (clk),
    .rst      (rst),
    .rollover (rollover),
    .pps      (pps)
  );

  assign tod            = tod_q;
  assign tod_valid      = (state_q == ST_SYNC);
  assign flowmeter_time = fm_q;

endmodule

// File: tb/tb_clipper_timebase.sv
// Scoreboard bench for clipper_timebase against an arithmetic ToD model.
module tb_clipper_timebase;

  localparam int unsigned NS_PER_CLK  = 8;
  localparam int unsigned ACCEL_SHIFT = 10;
  localparam int unsigned PPS_WIDTH   = 4;
  localparam logic [15:0] FRAC_NS     = 16'h0000;
  localparam longint      NSPS        = 64'd1_000_000_000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        timebase_force = 1'b0;
  logic        timebase_accelerate = 1'b0;
  logic [63:0] timebase_time = '0;
  logic        freeze_flowmeter_time = 1'b0;
  logic [63:0] tod;
  logic        tod_valid;
  logic [63:0] flowmeter_time;
  logic        pps;

  clipper_timebase #(
    .NS_PER_CLK  (NS_PER_CLK),
    .ACCEL_SHIFT (ACCEL_SHIFT),
    .PPS_WIDTH   (PPS_WIDTH),
    .FRAC_NS     (FRAC_NS)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .timebase_force        (timebase_force),
    .timebase_accelerate   (timebase_accelerate),
    .timebase_time         (timebase_time),
    .freeze_flowmeter_time (freeze_flowmeter_time),
    .tod                   (tod),
    .tod_valid             (tod_valid),
    .flowmeter_time        (flowmeter_time),
    .pps                   (pps)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] tod;
    logic        valid;
    logic [63:0] fm;
    logic        pps;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: plain integer time arithmetic, pps from cycles since last rollover.
  logic [31:0] m_sec;
  longint      m_ns;
  bit          m_valid;
  logic [63:0] m_fm;
  longint      m_cycle;
  longint      m_last_roll;
  int          m_frac;

  function automatic void model_reset();
    m_sec = '0; m_ns = 0; m_valid = 0; m_fm = '0;
    m_cycle = 0; m_last_roll = -1000; m_frac = 0;
  endfunction

  function automatic void model_step(bit f, bit a, logic [63:0] t, bit fr);
    bit     rolled;
    longint inc;
    rolled = 0;
    m_cycle++;
    if (f) begin
      m_sec   = t[63:32];
      m_ns    = {32'd0, t[31:0]};
      if (m_ns >= NSPS) m_ns = NSPS - 1;
      m_valid = 1;
      m_frac  = 0;
    end else begin
      inc = a ? (longint'(NS_PER_CLK) << ACCEL_SHIFT) : longint'(NS_PER_CLK);
`ifdef CLIPPER_TIMEBASE_DRIFT_EN
      m_frac += int'(FRAC_NS);
      if (m_frac >= 65536) begin
        m_frac -= 65536;
        inc++;
      end
`endif
      m_ns += inc;
      if (m_ns >= NSPS) begin
        m_ns  -= NSPS;
        m_sec += 32'd1;
        rolled = 1;
      end
    end
    if (!fr) m_fm = {m_sec, m_ns[31:0]};
    if (rolled) m_last_roll = m_cycle;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.tod   = {m_sec, m_ns[31:0]};
    e.valid = m_valid;
    e.fm    = m_fm;
    e.pps   = ((m_cycle - m_last_roll) < longint'(PPS_WIDTH));
    return e;
  endfunction

  // Called at a falling edge: drive, predict, then move on to the next falling edge.
  task automatic cyc(input bit f, input bit a, input logic [63:0] t, input bit fr);
    timebase_force        = f;
    timebase_accelerate   = a;
    timebase_time         = t;
    freeze_flowmeter_time = fr;
    model_step(f, a, t, fr);
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    timebase_force = 0; timebase_accelerate = 0;
    timebase_time = '0; freeze_flowmeter_time = 0;
    model_reset();
    exp_q.push_back(model_out());
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 64'd0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (tod !== e.tod) begin
          miscompares++;
          $display("FAIL tod @%0t: got %h expected %h", $time, tod, e.tod);
        end
        if (tod_valid !== e.valid) begin
          miscompares++;
          $display("FAIL tod_valid @%0t: got %b expected %b", $time, tod_valid, e.valid);
        end
        if (flowmeter_time !== e.fm) begin
          miscompares++;
          $display("FAIL flowmeter_time @%0t: got %h expected %h", $time, flowmeter_time, e.fm);
        end
        if (pps !== e.pps) begin
          miscompares++;
          $display("FAIL pps @%0t: got %b expected %b", $time, pps, e.pps);
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] ns_r;
    int          waited;
    @(negedge clk);
    do_reset();
    idle(10);
    cyc(1, 0, {32'd5, 32'd999_999_992}, 0);
    idle(8);
    cyc(1, 0, {32'd7, 32'd999_995_000}, 0);
    cyc(0, 1, 64'd0, 0);
    idle(3);
    cyc(1, 0, {32'hFFFF_FFFF, 32'd999_999_992}, 0);
    idle(6);
    cyc(1, 0, {32'd2, 32'd392}, 0);
    idle(1);
    repeat (20) cyc(0, 0, 64'd0, 1);
    idle(3);
    cyc(0, 0, 64'd0, 1);
    cyc(1, 0, {32'd9, 32'd9}, 1);
    idle(2);
    cyc(1, 0, {32'd3, 32'hFFFF_FFFF}, 0);
    idle(2);
    cyc(1, 0, {32'd1, 32'd999_999_992}, 0);
    idle(1);
    cyc(1, 0, {32'd1, 32'd999_999_992}, 0);
    idle(6);
    repeat (5) cyc(1, 1'($urandom_range(0, 1)), {$urandom(), $urandom()}, 0);
    idle(4);
    do_reset();
    idle(5);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       ns_r = $urandom();
        default: ns_r = NSPS[31:0] - 32'($urandom_range(1, 10000));
      endcase
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
          {$urandom(), ns_r}, $urandom_range(0, 3) == 0);
      if (i == 1500) do_reset();
    end
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
